// File: rtl/lsu_pkg.sv
// Shared types, size helpers and the async-reset register macro for the load/store unit.
`ifndef LSU_DFF_AR
`define LSU_DFF_AR(q, d, rv) \
    always_ff @(posedge clk or negedge rst_n) begin \
        if (!rst_n) q <= (rv); \
        else        q <= (d); \
    end
`endif

package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    function automatic logic [3:0] size2byten(input size_t sz);
        case (sz)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            SZ_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] size2bytes(input size_t sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_fault_chk.sv
// Combinational request screening: illegal size, out-of-range span, misalignment.
module lsu_fault_chk
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES    = 1024,
    parameter bit          STRICT_ALIGN = 1'b1
) (
    input  logic [31:0] addr,
    input  size_t       size,
    output logic        fault
);

    logic [32:0] end_addr;
    logic        misalign;

    always_comb begin
        // 33-bit sum so addresses near 2^32 cannot wrap back into range
        end_addr = {1'b0, addr} + {30'd0, size2bytes(size)};
        misalign = 1'b0;
        if (STRICT_ALIGN) begin
            case (size)
                SZ_H:    misalign = addr[0];
                SZ_W:    misalign = |addr[1:0];
                default: misalign = 1'b0;
            endcase
        end
        fault = (size == SZ_X) || (end_addr > 33'(MEM_BYTES)) || misalign;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one request at a time, fault screening, a single-cycle
// memory access and a registered response with saturating access counters.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES    = 1024,
    parameter bit          STRICT_ALIGN = 1'b1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic [31:0]      mem_adrs_rd,
    input  logic [31:0]      mem_rd_data,
    output logic             mem_wr_en,
    output logic [3:0]       mem_byt_en,
    output logic             mem_sign_ext,
    output logic [31:0]      mem_adrs_wr,
    output logic [31:0]      mem_wr_data,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] st_cnt,
    output logic [CNT_W-1:0] flt_cnt
);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    size_t             size_q, size_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d;
    logic [CNT_W-1:0]  st_cnt_q, st_cnt_d;
    logic [CNT_W-1:0]  flt_cnt_q, flt_cnt_d;
    logic              req_fault;
    size_t             req_sz;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign req_sz = size_t'(req_size);

    lsu_fault_chk #(
        .MEM_BYTES    (MEM_BYTES),
        .STRICT_ALIGN (STRICT_ALIGN)
    ) u_fault_chk (
        .addr  (req_addr),
        .size  (req_sz),
        .fault (req_fault)
    );

    `LSU_DFF_AR(state_q,    state_d,    IDLE)
    `LSU_DFF_AR(we_q,       we_d,       1'b0)
    `LSU_DFF_AR(uns_q,      uns_d,      1'b0)
    `LSU_DFF_AR(size_q,     size_d,     SZ_B)
    `LSU_DFF_AR(addr_q,     addr_d,     '0)
    `LSU_DFF_AR(wdata_q,    wdata_d,    '0)
    `LSU_DFF_AR(rsp_data_q, rsp_data_d, '0)
    `LSU_DFF_AR(rsp_err_q,  rsp_err_d,  1'b0)
    `LSU_DFF_AR(ld_cnt_q,   ld_cnt_d,   '0)
    `LSU_DFF_AR(st_cnt_q,   st_cnt_d,   '0)
    `LSU_DFF_AR(flt_cnt_q,  flt_cnt_d,  '0)

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = req_fault ? RESP : ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d       = we_q;
        uns_d      = uns_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        ld_cnt_d   = ld_cnt_q;
        st_cnt_d   = st_cnt_q;
        flt_cnt_d  = flt_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    uns_d      = req_unsigned;
                    size_d     = req_sz;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    rsp_err_d  = req_fault;
                    rsp_data_d = '0;
                end
            end
            ACCESS: rsp_data_d = we_q ? '0 : mem_rd_data;
            RESP: begin
                if (rsp_ready) begin
                    if (rsp_err_q)  flt_cnt_d = sat_inc(flt_cnt_q);
                    else if (we_q)  st_cnt_d  = sat_inc(st_cnt_q);
                    else            ld_cnt_d  = sat_inc(ld_cnt_q);
                    rsp_err_d  = 1'b0;
                    rsp_data_d = '0;
                end
            end
            default: ;
        endcase
    end

    // Memory ports are live only during ACCESS, so a store writes exactly once
    always_comb begin
        req_ready    = (state_q == IDLE);
        rsp_valid    = (state_q == RESP);
        mem_adrs_rd  = '0;
        mem_adrs_wr  = '0;
        mem_wr_en    = 1'b0;
        mem_byt_en   = '0;
        mem_sign_ext = 1'b0;
        mem_wr_data  = '0;
        if (state_q == ACCESS) begin
            mem_adrs_rd  = addr_q;
            mem_adrs_wr  = addr_q;
            mem_wr_en    = we_q;
            mem_byt_en   = size2byten(size_q);
            mem_sign_ext = !we_q && !uns_q;
            mem_wr_data  = wdata_q;
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign ld_cnt   = ld_cnt_q;
    assign st_cnt   = st_cnt_q;
    assign flt_cnt  = flt_cnt_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl: two instances (strict/16-bit counters and
// relaxed/2-bit counters) share a byte memory and a high-level reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    bit          sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;

    logic        rdy0, vld0, err0, wr_en0, se0;
    logic [31:0] data0, adrs_rd0, adrs_wr0, wdata0, rd0;
    logic [3:0]  be0;
    logic [15:0] ld0, st0, flt0;
    logic        rdy1, vld1, err1, wr_en1, se1;
    logic [31:0] data1, adrs_rd1, adrs_wr1, wdata1, rd1;
    logic [3:0]  be1;
    logic [1:0]  ld1, st1, flt1;

    logic [31:0] o_data, o_adrs_rd, o_adrs_wr, o_wdata, o_ld, o_st, o_flt;
    logic        o_ready, o_valid, o_err, o_wr_en, o_se;
    logic [3:0]  o_be;

    logic [7:0]  env_mem [0:1023];
    logic [7:0]  ref_mem [0:1023];
    int          wr_pulses = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned m_ld [2];
    int unsigned m_st [2];
    int unsigned m_flt [2];
    int unsigned m_max [2] = '{65535, 3};
    logic [31:0] got;

    always #5 clk = ~clk;

    lsu_ctrl #(.MEM_BYTES(1024), .STRICT_ALIGN(1'b1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & ~sel), .req_ready(rdy0), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(vld0), .rsp_ready(rsp_ready & ~sel),
        .rsp_data(data0), .rsp_err(err0), .mem_adrs_rd(adrs_rd0), .mem_rd_data(rd0),
        .mem_wr_en(wr_en0), .mem_byt_en(be0), .mem_sign_ext(se0),
        .mem_adrs_wr(adrs_wr0), .mem_wr_data(wdata0),
        .ld_cnt(ld0), .st_cnt(st0), .flt_cnt(flt0)
    );

    lsu_ctrl #(.MEM_BYTES(1024), .STRICT_ALIGN(1'b0), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & sel), .req_ready(rdy1), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(vld1), .rsp_ready(rsp_ready & sel),
        .rsp_data(data1), .rsp_err(err1), .mem_adrs_rd(adrs_rd1), .mem_rd_data(rd1),
        .mem_wr_en(wr_en1), .mem_byt_en(be1), .mem_sign_ext(se1),
        .mem_adrs_wr(adrs_wr1), .mem_wr_data(wdata1),
        .ld_cnt(ld1), .st_cnt(st1), .flt_cnt(flt1)
    );

    assign o_ready   = sel ? rdy1 : rdy0;
    assign o_valid   = sel ? vld1 : vld0;
    assign o_err     = sel ? err1 : err0;
    assign o_data    = sel ? data1 : data0;
    assign o_adrs_rd = sel ? adrs_rd1 : adrs_rd0;
    assign o_adrs_wr = sel ? adrs_wr1 : adrs_wr0;
    assign o_wdata   = sel ? wdata1 : wdata0;
    assign o_wr_en   = sel ? wr_en1 : wr_en0;
    assign o_se      = sel ? se1 : se0;
    assign o_be      = sel ? be1 : be0;
    assign o_ld      = sel ? {30'd0, ld1}  : {16'd0, ld0};
    assign o_st      = sel ? {30'd0, st1}  : {16'd0, st0};
    assign o_flt     = sel ? {30'd0, flt1} : {16'd0, flt0};

    // Byte memory: combinational read with byte-enable selection and sign extension
    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [3:0] be, input logic se);
        logic [31:0] v = '0;
        logic [31:0] ai;
        for (int i = 0; i < 4; i++) begin
            ai = a + 32'(i);
            if (be[i] && ai < 32'd1024) v[8*i +: 8] = env_mem[ai[9:0]];
        end
        if (se && be == 4'b0001) v[31:8] = {24{v[7]}};
        else if (se && be == 4'b0011) v[31:16] = {16{v[15]}};
        return v;
    endfunction

    always_comb rd0 = mem_read(adrs_rd0, be0, se0);
    always_comb rd1 = mem_read(adrs_rd1, be1, se1);

    always @(posedge clk) begin
        if (wr_en0) begin
            for (int i = 0; i < 4; i++)
                if (be0[i] && (adrs_wr0 + 32'(i)) < 32'd1024)
                    env_mem[10'(adrs_wr0 + 32'(i))] <= wdata0[8*i +: 8];
            wr_pulses <= wr_pulses + 1;
        end
        if (wr_en1) begin
            for (int i = 0; i < 4; i++)
                if (be1[i] && (adrs_wr1 + 32'(i)) < 32'd1024)
                    env_mem[10'(adrs_wr1 + 32'(i))] <= wdata1[8*i +: 8];
            wr_pulses <= wr_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    function automatic bit model_fault(input logic [1:0] size, input logic [31:0] addr, input bit strict);
        longint unsigned nb = 64'd1 << size;
        longint unsigned a  = addr;
        if (size == 2'd3) return 1'b1;
        if (a + nb > 64'd1024) return 1'b1;
        if (strict && (a % nb) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input int unsigned addr, input int unsigned nb, input bit uns);
        logic [31:0] v = '0;
        for (int unsigned i = 0; i < nb; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    task automatic check_counters(input string tag);
        check({tag, "_ld"},  o_ld,  m_ld[sel]);
        check({tag, "_st"},  o_st,  m_st[sel]);
        check({tag, "_flt"}, o_flt, m_flt[sel]);
    endtask

    task automatic do_req(input bit s, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int unsigned hold, output logic [31:0] rsp);
        bit          flt;
        int unsigned nb, lat;
        int          pulses0;
        logic [31:0] exp_data;
        sel = s;
        @(negedge clk);
        check("req_ready_idle", {31'd0, o_ready}, 32'd1);
        flt = model_fault(size, addr, !s);
        nb = 1 << size;
        exp_data = '0;
        if (!flt && !we) exp_data = model_load(addr, nb, uns);
        if (!flt && we)
            for (int unsigned i = 0; i < nb; i++) ref_mem[addr + i] = wdata[8*i +: 8];
        pulses0 = wr_pulses;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        // junk on the request bus while busy must be ignored
        req_valid = 1'($urandom); req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                if (!flt) begin
                    check("acc_byten",   {28'd0, o_be}, (32'd1 << nb) - 32'd1);
                    check("acc_adrs_rd", o_adrs_rd, addr);
                    check("acc_adrs_wr", o_adrs_wr, addr);
                    check("acc_wr_en",   {31'd0, o_wr_en}, {31'd0, we});
                    check("acc_sign",    {31'd0, o_se}, {31'd0, !we && !uns});
                    check("acc_wdata",   o_wdata, wdata);
                    check("acc_ready",   {31'd0, o_ready}, 32'd0);
                end else begin
                    check("flt_byten", {28'd0, o_be}, 32'd0);
                    check("flt_wr_en", {31'd0, o_wr_en}, 32'd0);
                end
            end
        end while (!o_valid && lat < 8);
        check("latency",  lat, flt ? 32'd1 : 32'd2);
        check("rsp_err",  {31'd0, o_err}, {31'd0, flt});
        check("rsp_data", o_data, exp_data);
        rsp = o_data;
        repeat (hold) begin
            @(negedge clk);
            check("hold_valid", {31'd0, o_valid}, 32'd1);
            check("hold_data",  o_data, exp_data);
            check("hold_err",   {31'd0, o_err}, {31'd0, flt});
            check("hold_ready", {31'd0, o_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        if (flt) m_flt[s] = (m_flt[s] < m_max[s]) ? m_flt[s] + 1 : m_flt[s];
        else if (we) m_st[s] = (m_st[s] < m_max[s]) ? m_st[s] + 1 : m_st[s];
        else m_ld[s] = (m_ld[s] < m_max[s]) ? m_ld[s] + 1 : m_ld[s];
        @(negedge clk);
        check("post_valid", {31'd0, o_valid}, 32'd0);
        check("post_ready", {31'd0, o_ready}, 32'd1);
        check_counters("cnt");
        check("wr_pulses", 32'(wr_pulses - pulses0), (!flt && we) ? 32'd1 : 32'd0);
        if (we)
            for (int unsigned i = 0; i < 4; i++)
                if (64'(addr) + i < 64'd1024)
                    check("mem_byte", {24'd0, env_mem[addr + i]}, {24'd0, ref_mem[addr + i]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        for (int i = 0; i < 2; i++) begin m_ld[i] = 0; m_st[i] = 0; m_flt[i] = 0; end
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, vld0}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en0}, 32'd0);
        check("rst_byten", {28'd0, be0}, 32'd0);
        check("rst_data",  data0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, rdy0}, 32'd1);
        check_counters("rst_cnt");

        do_req(0, 1, 2'd0, 0, 32'h010, 32'h0000_00A5, 0, got);
        do_req(0, 0, 2'd0, 0, 32'h010, 32'h0, 0, got);
        check("tp_ld_sb", got, 32'hFFFF_FFA5);
        do_req(0, 0, 2'd0, 1, 32'h010, 32'h0, 1, got);
        check("tp_ld_ub", got, 32'h0000_00A5);
        check("tp_st_cnt", o_st, 32'd1);
        check("tp_ld_cnt", o_ld, 32'd2);

        do_req(0, 1, 2'd1, 0, 32'h022, 32'h1234_8001, 0, got);
        check("tp_b22", {24'd0, env_mem[10'h022]}, 32'h01);
        check("tp_b23", {24'd0, env_mem[10'h023]}, 32'h80);
        do_req(0, 0, 2'd1, 1, 32'h022, 32'h0, 0, got);
        check("tp_ld_uh", got, 32'h0000_8001);
        do_req(0, 0, 2'd1, 0, 32'h022, 32'h0, 2, got);
        check("tp_ld_sh", got, 32'hFFFF_8001);

        do_req(0, 0, 2'd2, 0, 32'h013, 32'h0, 0, got);
        check("tp_misalign_data", got, 32'd0);
        check("tp_flt_cnt", o_flt, 32'd1);
        do_req(1, 0, 2'd2, 0, 32'h013, 32'h0, 0, got);
        check("tp_relaxed_word", got, {env_mem[10'h016], env_mem[10'h015], env_mem[10'h014], env_mem[10'h013]});

        do_req(0, 1, 2'd2, 0, 32'h3FE, 32'hDEAD_BEEF, 0, got);
        do_req(0, 1, 2'd2, 0, 32'h3FC, 32'h0BAD_F00D, 0, got);
        do_req(0, 1, 2'd2, 0, 32'h200, 32'h5555_AAAA, 5, got);

        // reset while the response is pending
        sel = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h100; req_wdata = 32'hCAFE_F00D;
        for (int unsigned i = 0; i < 4; i++) ref_mem[32'h100 + i] = req_wdata[8*i +: 8];
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_valid", {31'd0, vld0}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, vld0}, 32'd0);
        check("rst_mid_data",  data0, 32'd0);
        check("rst_mid_wr_en", {31'd0, wr_en0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin m_ld[i] = 0; m_st[i] = 0; m_flt[i] = 0; end
        @(negedge clk);
        check("rst_rel_ready0", {31'd0, rdy0}, 32'd1);
        check("rst_rel_ready1", {31'd0, rdy1}, 32'd1);
        check_counters("rst_rel_cnt");

        repeat (5) do_req(1, 0, 2'd2, 1, 32'h040, 32'h0, 0, got);
        check("tp_sat_ld", o_ld, 32'd3);

        for (int n = 0; n < 300; n++) begin
            int unsigned r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else if (r < 3)  a = 32'($urandom_range(1016, 1030));
            else             a = 32'($urandom_range(0, 1023));
            do_req(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
                   $urandom_range(0, 3), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator between the core's execute stage and the 1 KB byte-addressable data memory.
- Accepts one load/store request at a time via a valid/ready handshake and checks it for faults.
- Drives the memory's read/write address, byte-enable, sign-extend and write-data ports for exactly one cycle.
- Returns the result through a registered valid/ready response, with saturating per-type access counters.

Parameters:
- MEM_BYTES, 1024, size of the addressable memory in bytes; accesses must lie fully within [0, MEM_BYTES-1].
- STRICT_ALIGN, 1, 1 = halfword/word accesses must be naturally aligned or fault; 0 = any byte address allowed.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  load result; 0 for stores and faults
- rsp_err  out  1  request faulted, no memory access made
- mem_adrs_rd  out  32  memory read address
- mem_rd_data  in  32  memory combinational read data
- mem_wr_en  out  1  memory write enable
- mem_byt_en  out  4  memory byte enables, shared by read and write
- mem_sign_ext  out  1  memory sign-extend enable
- mem_adrs_wr  out  32  memory write address
- mem_wr_data  out  32  memory write data
- ld_cnt, st_cnt, flt_cnt  out  CNT_W each  completed loads, completed stores, faults

Behaviour:
- Reset: asynchronous on rst_n low.
  - State returns to IDLE.
  - All registers and counters are cleared to 0.
  - rsp_valid, rsp_err, rsp_data, mem_wr_en and mem_byt_en are 0.
  - req_ready is 1 once rst_n is high.
- State IDLE: req_ready = 1. When req_valid is high, the request fields are latched and fault_chk is evaluated.
  - A fault occurs on any of:
    - req_size = 3.
    - addr + bytes > MEM_BYTES, where bytes = 1, 2 or 4; computed in 33 bits so it cannot wrap.
    - STRICT_ALIGN = 1 and (size = 1 and addr[0] = 1, or size = 2 and addr[1:0] != 0).
  - No fault: go to ACCESS. Fault: go to RESP with err = 1, data = 0 and no ACCESS cycle.
- State ACCESS: lasts exactly 1 cycle.
  - mem_adrs_rd = mem_adrs_wr = latched address.
  - mem_byt_en = 0001, 0011 or 1111 for byte, half or word.
  - mem_sign_ext = !unsigned for loads, 0 for stores.
  - mem_wr_data = latched wdata.
  - mem_wr_en = we.
  - Loads capture mem_rd_data into the response register at the end of the cycle. Stores capture 0.
  - Next state is RESP.
- State RESP: rsp_valid = 1.
  - rsp_data and rsp_err are held stable until rsp_ready is high.
  - On the handshake, the matching counter increments: ld_cnt, st_cnt or flt_cnt.
  - Counters saturate at all-ones.
  - Next state is IDLE. No same-cycle re-accept; req_ready rises the following cycle.
- Outside ACCESS, every mem_* output is 0.
  - A store's memory write therefore occurs exactly once, however long backpressure lasts.
- Latency:
  - Good request: rsp_valid 2 cycles after acceptance.
  - Faulted request: rsp_valid 1 cycle after acceptance.
  - Throughput is 1 request per 3 cycles.
- rst_n asserted during ACCESS: mem_wr_en drops immediately and the pending response is discarded. Whether the in-flight write takes effect is defined only if rst_n falls after the clock edge that ends ACCESS.
- req fields are ignored in every state except IDLE.

Decomposition:
- lsu_pkg holds:
  - size_t enum: SZ_B, SZ_H, SZ_W, SZ_X.
  - state_t enum: IDLE, ACCESS, RESP.
  - function size2byten(size_t) returning 4 bits.
  - function size2bytes(size_t) returning 3 bits.
- One sub-module, lsu_fault_chk: combinational; inputs addr, size and parameters; output fault.
- State, request and response registers use the shared DFF macros, with async active-low reset.

Test Plan:
- Signed byte load: store byte 0xA5 at 0x010, then load signed byte from 0x010 -> rsp_data = 0xFFFFFFA5, rsp_err = 0. The unsigned byte load returns 0x000000A5. st_cnt = 1, ld_cnt = 2.
- Halfword round trip: store half with wdata 0x12348001 at 0x022 -> memory bytes 0x022 = 0x01 and 0x023 = 0x80. Unsigned half load -> 0x00008001. Signed half load -> 0xFFFF8001.
- Misaligned word load: load word at 0x013 with STRICT_ALIGN = 1 -> rsp_err = 1, rsp_data = 0, rsp_valid 1 cycle after accept, mem_byt_en never nonzero, flt_cnt = 1. With STRICT_ALIGN = 0 the load succeeds and returns bytes 0x013..0x016.
- Out-of-range store: store word at 0x3FE -> fault, mem_wr_en stays 0, memory unchanged. Store word at 0x3FC succeeds.
- Backpressure: store with rsp_ready held low for 5 cycles -> mem_wr_en high exactly 1 cycle, rsp_valid and rsp_data stable for 6 cycles, req_ready low throughout.
- Reset and saturation: rst_n low mid-RESP -> rsp_valid is 0 immediately, req_ready is 1 after release, all counters are 0. With CNT_W = 2, 5 loads -> ld_cnt = 3.
